// File: rtl/slv_guard_rst_ctrl.sv
// Reset-request servicer for the subordinate guard: pulses an active-low reset into the
// subordinate, settles, acknowledges, retries on a stuck request and latches a sticky failure.
module slv_guard_rst_ctrl #(
    parameter int unsigned RstCycles    = 16,
    parameter int unsigned SettleCycles = 8,
    parameter int unsigned AckTimeout   = 64,
    parameter int unsigned MaxRetries   = 3,
    parameter int unsigned CntWidth     = 10,
    parameter int unsigned RetryWidth   = $clog2(MaxRetries + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rst_req_i,
    input  logic                  fail_clr_i,
    output logic                  rst_stat_o,
    output logic                  sub_rst_no,
    output logic                  isolate_o,
    output logic                  busy_o,
    output logic                  fail_o,
    output logic [RetryWidth-1:0] attempt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StSettle,
        StAck,
        StFail
    } state_e;

    localparam logic [CntWidth-1:0]   CntOne     = CntWidth'(1);
    localparam logic [CntWidth-1:0]   CntMax     = '1;
    localparam logic [CntWidth-1:0]   RstLast    = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0]   SettleLast = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0]   AckLast    = CntWidth'(AckTimeout - 1);
    localparam logic [RetryWidth-1:0] AttOne     = RetryWidth'(1);
    localparam logic [RetryWidth-1:0] AttMax     = RetryWidth'(MaxRetries);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [RetryWidth-1:0] attempt_q, attempt_d;
    logic [CntWidth-1:0]   cnt_inc;

    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        attempt_d = attempt_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rst_req_i) begin
                    state_d   = StAssert;
                    attempt_d = AttOne;
                end
            end
            StAssert: begin
                if (cnt_q == RstLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StAck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StAck: begin
                // A withdrawn request always wins over the timeout on the same cycle.
                if (!rst_req_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == AckLast) begin
                    cnt_d = '0;
                    if (attempt_q < AttMax) begin
                        state_d   = StAssert;
                        attempt_d = attempt_q + AttOne;
                    end else begin
                        state_d = StFail;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StFail: begin
                cnt_d = '0;
                if (fail_clr_i) begin
                    state_d   = StIdle;
                    attempt_d = '0;
                end
            end
            default: begin
                state_d   = StIdle;
                cnt_d     = '0;
                attempt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            attempt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            attempt_q <= attempt_d;
        end
    end

    // Outputs decode the registered state only, so no input reaches an output combinationally.
    assign rst_stat_o = (state_q == StAck);
    assign sub_rst_no = !((state_q == StAssert) || (state_q == StFail));
    assign isolate_o  = (state_q != StIdle);
    assign busy_o     = (state_q != StIdle);
    assign fail_o     = (state_q == StFail);
    assign attempt_o  = attempt_q;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl: a default-parameter instance plus a short-timing
// instance (RstCycles=1, SettleCycles=1, AckTimeout=4, MaxRetries=2) for boundary cases.
module tb_slv_guard_rst_ctrl;

    localparam int RST    = 16;
    localparam int SETTLE = 8;
    localparam int ACKTO  = 64;
    localparam int PERIOD = RST + SETTLE + ACKTO;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       rst_req_i = 1'b0;
    logic       fail_clr_i = 1'b0;
    logic       rst_stat_o, sub_rst_no, isolate_o, busy_o, fail_o;
    logic [1:0] attempt_o;

    logic       reqF = 1'b0;
    logic       clrF = 1'b0;
    logic       statF, subF, isoF, busyF, failF;
    logic [1:0] attF;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    slv_guard_rst_ctrl u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rst_req_i  (rst_req_i),
        .fail_clr_i (fail_clr_i),
        .rst_stat_o (rst_stat_o),
        .sub_rst_no (sub_rst_no),
        .isolate_o  (isolate_o),
        .busy_o     (busy_o),
        .fail_o     (fail_o),
        .attempt_o  (attempt_o)
    );

    slv_guard_rst_ctrl #(
        .RstCycles    (1),
        .SettleCycles (1),
        .AckTimeout   (4),
        .MaxRetries   (2),
        .CntWidth     (4)
    ) u_fast (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rst_req_i  (reqF),
        .fail_clr_i (clrF),
        .rst_stat_o (statF),
        .sub_rst_no (subF),
        .isolate_o  (isoF),
        .busy_o     (busyF),
        .fail_o     (failF),
        .attempt_o  (attF)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic req, input logic clr, input logic rst);
        rst_req_i  = req;
        fail_clr_i = clr;
        rst_i      = rst;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkMain(input string tag, input logic stat, input logic sub, input logic iso,
                             input logic busy, input logic fail, input logic [1:0] att);
        checkOutput({tag, ".stat"}, 8'(rst_stat_o), 8'(stat));
        checkOutput({tag, ".subrstn"}, 8'(sub_rst_no), 8'(sub));
        checkOutput({tag, ".isolate"}, 8'(isolate_o), 8'(iso));
        checkOutput({tag, ".busy"}, 8'(busy_o), 8'(busy));
        checkOutput({tag, ".fail"}, 8'(fail_o), 8'(fail));
        checkOutput({tag, ".attempt"}, 8'(attempt_o), 8'(att));
    endtask

    task automatic checkFast(input string tag, input logic stat, input logic sub, input logic iso,
                             input logic busy, input logic fail, input logic [1:0] att);
        checkOutput({tag, ".stat"}, 8'(statF), 8'(stat));
        checkOutput({tag, ".subrstn"}, 8'(subF), 8'(sub));
        checkOutput({tag, ".isolate"}, 8'(isoF), 8'(iso));
        checkOutput({tag, ".busy"}, 8'(busyF), 8'(busy));
        checkOutput({tag, ".fail"}, 8'(failF), 8'(fail));
        checkOutput({tag, ".attempt"}, 8'(attF), 8'(att));
    endtask

    // Tick k of an attempt: k=1..16 ASSERT, 17..24 SETTLE, 25..88 ACK.
    task automatic runAttempt(input string tag, input logic [1:0] att, input int nTicks);
        for (int k = 1; k <= nTicks; k++) begin
            tick();
            checkMain($sformatf("%s.k%0d", tag, k), (k > RST + SETTLE), (k > RST), 1'b1, 1'b1, 1'b0, att);
        end
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick(3);
        checkMain("reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        checkFast("resetF", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(2);
        checkMain("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Test 1: nominal request, withdrawn as soon as the acknowledge is seen.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runAttempt("t1", 2'd1, RST + SETTLE + 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkMain("t1.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // Test 3: single-cycle request pulse still runs the full sequence.
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick();
        checkMain("t3.k1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= RST + SETTLE + 1; k++) begin
            tick();
            checkMain($sformatf("t3.k%0d", k), (k > RST + SETTLE), (k > RST), 1'b1, 1'b1, 1'b0, 2'd1);
        end
        tick();
        checkMain("t3.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        // Test 2: request never withdrawn -> three attempts then sticky FAIL.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runAttempt("t2.a1", 2'd1, PERIOD);
        runAttempt("t2.a2", 2'd2, PERIOD);
        runAttempt("t2.a3", 2'd3, PERIOD);
        tick();
        checkMain("t2.fail", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick(10);
        checkMain("t2.hold", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkMain("t2.clr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Test 4: synchronous reset five cycles into ASSERT aborts with no acknowledge.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runAttempt("t4", 2'd1, 5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkMain("t4.rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            tick();
            checkOutput($sformatf("t4.nostat%0d", k), 8'(rst_stat_o), 8'd0);
        end

        // Test 5: request withdrawn ten cycles into the second ACK window.
        applyStimulus(1'b1, 1'b0, 1'b0);
        runAttempt("t5.a1", 2'd1, PERIOD);
        runAttempt("t5.a2", 2'd2, RST + SETTLE + 10);
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkMain("t5.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Test 6: fail_clr_i in IDLE is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkMain("t6.clrIdle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);

        // Short-timing instance: ACK three cycles after the request is sampled.
        reqF = 1'b1;
        tick();
        checkFast("f.assert", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        tick();
        checkFast("f.settle", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick();
        checkFast("f.ack", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        clrF = 1'b1;
        tick();
        clrF = 1'b0;
        checkFast("f.clrAck", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick(2);
        checkFast("f.ackLast", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick();
        checkFast("f.retry", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(2);
        checkFast("f.ack2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick(3);
        checkFast("f.ack2Last", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2);
        tick();
        checkFast("f.fail", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2);
        clrF = 1'b1;
        tick();
        clrF = 1'b0;
        checkFast("f.clrReq", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        tick();
        checkFast("f.newReq", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1);
        reqF = 1'b0;
        tick(2);
        checkFast("f.newAck", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
        tick();
        checkFast("f.newDone", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
